// File: rtl/fcmp_share_arb.sv
// fcmp_share_arb: round-robin arbiter time-sharing one FP compare datapath between two requesters.
// Optional per-requester grant and conflict counters when FCMP_SHARE_ARB_PERF_EN is defined.
module fcmp_share_arb #(
  parameter int TAG_W = 4,
  parameter logic [3:0] CTRL_FEQ = 4'b1010,
  parameter logic [3:0] CTRL_FLT = 4'b1011,
  parameter logic [3:0] CTRL_FLE = 4'b1100
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef FCMP_SHARE_ARB_PERF_EN
  output logic [31:0]      o_perf_grant0,
  output logic [31:0]      o_perf_grant1,
  output logic [31:0]      o_perf_conflict,
`endif
  input  logic [1:0]       i_req_valid,
  output logic [1:0]       o_req_ready,
  input  logic [31:0]      i_req0_a,
  input  logic [31:0]      i_req0_b,
  input  logic [31:0]      i_req1_a,
  input  logic [31:0]      i_req1_b,
  input  logic [1:0]       i_req0_op,
  input  logic [1:0]       i_req1_op,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic [TAG_W-1:0] i_req1_tag,
  output logic [31:0]      o_cmp_a,
  output logic [31:0]      o_cmp_b,
  output logic [3:0]       o_cmp_ctrl,
  input  logic [31:0]      i_cmp_r,
  output logic [1:0]       o_rsp_valid,
  input  logic [1:0]       i_rsp_ready,
  output logic [31:0]      o_rsp0_r,
  output logic [31:0]      o_rsp1_r,
  output logic [TAG_W-1:0] o_rsp0_tag,
  output logic [TAG_W-1:0] o_rsp1_tag
);
  logic [31:0]      w_a [2];
  logic [31:0]      w_b [2];
  logic [1:0]       w_op [2];
  logic [TAG_W-1:0] w_tag [2];
  logic [1:0]       w_elig, w_grant, w_win_op;
  logic             w_any, w_win;
  logic [1:0]       r_rsp_valid;
  logic [31:0]      r_rsp_r [2];
  logic [TAG_W-1:0] r_rsp_tag [2];
  logic             r_pri;
  assign w_a   = '{i_req0_a, i_req1_a};
  assign w_b   = '{i_req0_b, i_req1_b};
  assign w_op  = '{i_req0_op, i_req1_op};
  assign w_tag = '{i_req0_tag, i_req1_tag};
  // A slot may accept when empty or being drained this cycle; grants are suppressed in reset.
  assign w_elig   = i_rst_n ? (i_req_valid & (~r_rsp_valid | i_rsp_ready)) : 2'b00;
  assign w_grant  = (&w_elig) ? (r_pri ? 2'b10 : 2'b01) : w_elig;
  assign w_any    = |w_grant;
  assign w_win    = w_grant[1];
  assign w_win_op = w_op[w_win];
  assign o_req_ready = w_grant;
  assign o_cmp_a     = w_any ? w_a[w_win] : 32'h0;
  assign o_cmp_b     = w_any ? w_b[w_win] : 32'h0;
  assign o_cmp_ctrl  = !w_any ? CTRL_FEQ : (w_win_op == 2'b01) ? CTRL_FLT :
                       (w_win_op == 2'b10) ? CTRL_FLE : CTRL_FEQ;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp0_r    = r_rsp_r[0];
  assign o_rsp1_r    = r_rsp_r[1];
  assign o_rsp0_tag  = r_rsp_tag[0];
  assign o_rsp1_tag  = r_rsp_tag[1];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pri <= 1'b0;
    else if (w_any) r_pri <= w_grant[0];
  end
  // Reserved op still takes the slot but returns zero instead of the comparator output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 2'b00;
      r_rsp_r     <= '{32'h0, 32'h0};
      r_rsp_tag   <= '{'0, '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_grant[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_r[i]     <= (w_op[i] == 2'b11) ? 32'h0 : i_cmp_r;
          r_rsp_tag[i]   <= w_tag[i];
        end else if (i_rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end
`ifdef FCMP_SHARE_ARB_PERF_EN
  logic [31:0] r_perf_grant0, r_perf_grant1, r_perf_conflict;
  assign o_perf_grant0   = r_perf_grant0;
  assign o_perf_grant1   = r_perf_grant1;
  assign o_perf_conflict = r_perf_conflict;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_grant0   <= 32'h0;
      r_perf_grant1   <= 32'h0;
      r_perf_conflict <= 32'h0;
    end else begin
      r_perf_grant0   <= r_perf_grant0 + {31'h0, w_grant[0]};
      r_perf_grant1   <= r_perf_grant1 + {31'h0, w_grant[1]};
      r_perf_conflict <= r_perf_conflict + {31'h0, &w_elig};
    end
  end
`endif
endmodule

// File: tb/tb_fcmp_share_arb.sv
// tb_fcmp_share_arb: directed self-checking bench with a behavioural comparator for positive operands.
module tb_fcmp_share_arb;
  localparam int TAG_W = 4;
  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [1:0]       req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic [31:0]      cmp_a, cmp_b, cmp_r, rsp0_r, rsp1_r;
  logic [3:0]       cmp_ctrl;
`ifdef FCMP_SHARE_ARB_PERF_EN
  logic [31:0]      perf_g0, perf_g1, perf_cf;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // Positive IEEE singles order like unsigned integers, which is all this bench drives.
  assign cmp_r = (cmp_ctrl == 4'b1010) ? {31'h0, cmp_a == cmp_b} :
                 (cmp_ctrl == 4'b1011) ? {31'h0, cmp_a <  cmp_b} :
                 (cmp_ctrl == 4'b1100) ? {31'h0, cmp_a <= cmp_b} : 32'h0;
  fcmp_share_arb #(.TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
`ifdef FCMP_SHARE_ARB_PERF_EN
    .o_perf_grant0(perf_g0), .o_perf_grant1(perf_g1), .o_perf_conflict(perf_cf),
`endif
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req1_a(req1_a), .i_req1_b(req1_b),
    .i_req0_op(req0_op), .i_req1_op(req1_op), .i_req0_tag(req0_tag), .i_req1_tag(req1_tag),
    .o_cmp_a(cmp_a), .o_cmp_b(cmp_b), .o_cmp_ctrl(cmp_ctrl), .i_cmp_r(cmp_r),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp0_r(rsp0_r), .o_rsp1_r(rsp1_r), .o_rsp0_tag(rsp0_tag), .o_rsp1_tag(rsp1_tag)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req0_op = op; req0_a = a; req0_b = b; req0_tag = t;
  endtask
  task automatic set1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    req1_op = op; req1_a = a; req1_b = b; req1_tag = t;
  endtask
  initial begin
    rst_n = 1'b0; rsp_ready = 2'b00; req_valid = 2'b11;
    set0(2'b01, F1, F2, 4'hA);
    set1(2'b10, F2, F1, 4'hB);
    @(negedge clk); #1;
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp0_r", rsp0_r, 0);
    check("rst_rsp1_tag", rsp1_tag, 0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_cmp_a", cmp_a, 0);
    check("rst_cmp_ctrl", cmp_ctrl, 4'b1010);
    rst_n = 1'b1; req_valid = 2'b00;
    step();
    set0(2'b01, F1, F2, 4'h5); req_valid = 2'b01; #1;
    check("t1_ready", req_ready, 2'b01);
    check("t1_ctrl", cmp_ctrl, 4'b1011);
    check("t1_cmp_a", cmp_a, F1);
    step();
    req_valid = 2'b00; #1;
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_rsp0_r", rsp0_r, 1);
    check("t1_rsp0_tag", rsp0_tag, 4'h5);
    step();
    check("t1_hold", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    step();
    check("t1_pop", rsp_valid, 2'b00);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    rsp_ready = 2'b11;
    set0(2'b01, F1, F2, 4'h1);
    set1(2'b10, F2, F1, 4'h2);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("t2_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      step();
    end
    #1;
    check("t2_pri_back0", req_ready, 2'b01);
    check("t2_rsp_valid", rsp_valid, 2'b10);
    check("t2_rsp1_r", rsp1_r, 0);
    check("t2_rsp1_tag", rsp1_tag, 4'h2);
    step();
    req_valid = 2'b00; #1;
    check("t2_rsp_valid2", rsp_valid, 2'b01);
    check("t2_rsp0_r", rsp0_r, 1);
    step();
    rsp_ready = 2'b00;
    set0(2'b00, F1, F1, 4'h3); req_valid = 2'b01; #1;
    check("t3_first", req_ready, 2'b01);
    step();
    set0(2'b01, F2, F1, 4'h9);
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("t3_blocked%0d", k), req_ready, 2'b00);
      check($sformatf("t3_held%0d", k), rsp0_r, 1);
      step();
    end
    rsp_ready = 2'b01; #1;
    check("t3_nobubble", req_ready, 2'b01);
    step();
    req_valid = 2'b00; #1;
    check("t3_reload_valid", rsp_valid, 2'b01);
    check("t3_reload_r", rsp0_r, 0);
    check("t3_reload_tag", rsp0_tag, 4'h9);
    step();
    check("t3_drain", rsp_valid, 2'b00);
    rsp_ready = 2'b00;
    set1(2'b11, F1, F1, 4'h7); req_valid = 2'b10; #1;
    check("t4_ready", req_ready, 2'b10);
    check("t4_ctrl", cmp_ctrl, 4'b1010);
    step();
    req_valid = 2'b00; #1;
    check("t4_rsp_valid", rsp_valid, 2'b10);
    check("t4_rsp1_r", rsp1_r, 0);
    check("t4_rsp1_tag", rsp1_tag, 4'h7);
    rsp_ready = 2'b10;
    step();
    check("t4_pop", rsp_valid, 2'b00);
    rsp_ready = 2'b11; req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    rsp_ready = 2'b00;
    set0(2'b10, F2, F2, 4'h4); req_valid = 2'b01; #1;
    check("t5_ready", req_ready, 2'b01);
    check("t5_ctrl", cmp_ctrl, 4'b1100);
    #1 rst_n = 1'b0; #1;
    check("t5_rst_valid", rsp_valid, 2'b00);
    check("t5_rst_ready", req_ready, 2'b00);
    req_valid = 2'b00;
    step();
    rst_n = 1'b1; #1;
    check("t5_no_rsp", rsp_valid, 2'b00);
    rsp_ready = 2'b11; req_valid = 2'b11; #1;
    check("t5_pri0", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
`ifdef FCMP_SHARE_ARB_PERF_EN
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req_valid = 2'b11;
    repeat (4) step();
    req_valid = 2'b01;
    repeat (2) step();
    req_valid = 2'b00; #1;
    check("perf_grant0", perf_g0, 4);
    check("perf_grant1", perf_g1, 2);
    check("perf_conflict", perf_cf, 4);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fcmp_share_arb.md
Name: fcmp_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer for the shared FP compare datapath (equal / less-than / less-equal, combinational, 32-bit result).
- Lets the scalar FP pipe (requester 0) and the FMIN/FMAX/branch-helper path (requester 1) time-share one comparator instance.
- Translates each request's compare op into the comparator's 4-bit FPU_Control code, then registers the result into a per-requester response slot with valid/ready handshake.

Parameters:
TAG_W, 4, width of the opaque request tag returned with each response
CTRL_FEQ, 4'b1010, FPU_Control code that selects the equal result
CTRL_FLT, 4'b1011, FPU_Control code that selects the less-than result
CTRL_FLE, 4'b1100, FPU_Control code that selects the less-equal result

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  2  per-requester request valid (bit i = requester i)
REQ_READY  out  2  per-requester request accepted this cycle
REQ0_A, REQ0_B  in  32  requester 0 operands
REQ1_A, REQ1_B  in  32  requester 1 operands
REQ0_OP, REQ1_OP  in  2  00 FEQ, 01 FLT, 10 FLE, 11 reserved
REQ0_TAG, REQ1_TAG  in  TAG_W  request tags
CMP_A, CMP_B  out  32  operands driven to the comparator
CMP_CTRL  out  4  FPU_Control driven to the comparator
CMP_R  in  32  comparator result (combinational, same cycle)
RSP_VALID  out  2  per-requester response valid
RSP_READY  in  2  per-requester response consumed
RSP0_R, RSP1_R  out  32  registered compare results
RSP0_TAG, RSP1_TAG  out  TAG_W  returned tags

Behaviour:
- Reset:
  - RSP_VALID=0, RSP*_R=0, RSP*_TAG=0.
  - Round-robin pointer PRI=0 (requester 0 favoured).
  - CMP_A/B=0, CMP_CTRL=CTRL_FEQ. Async assert, sync deassert handled upstream.
- Eligibility: requester i is eligible iff REQ_VALID[i] && (!RSP_VALID[i] || RSP_READY[i]). Its slot must be free, or drained in the same cycle.
- Grant:
  - One eligible → it wins.
  - Both eligible → PRI wins.
  - After any grant, PRI = ~winner.
  - No grant → PRI holds.
- REQ_READY = one-hot grant, combinational. A request is accepted when REQ_VALID[i] && REQ_READY[i].
- Comparator muxing:
  - CMP_A/B come from the winner's operands.
  - CMP_CTRL is the op mapped to CTRL_FEQ/FLT/FLE.
  - With no grant, operands are driven to 0 and CMP_CTRL to CTRL_FEQ (no X propagation).
- Capture: on acceptance, at the next edge RSP_VALID[i]=1, RSPi_R=CMP_R, RSPi_TAG=REQi_TAG. Latency is one cycle.
- Reserved op 11: the request is still granted and consumes a slot, but RSPi_R=32'h0. The comparator output is ignored.
- Response hold: RSP_VALID[i] and the data stay stable until RSP_READY[i]=1.
  - Pop without new acceptance → RSP_VALID[i]=0.
  - Pop with acceptance in the same cycle → slot reloads; RSP_VALID stays 1.
- Throughput: one compare per cycle in aggregate. A single requester with RSP_READY held high gets back-to-back acceptance.
- Only one requester is granted per cycle. The other requester's slot updates only via its own pop.
- Reset mid-transaction drops pending responses. No partial state survives reset.

Optional Feature:
- Macro: FCMP_SHARE_ARB_PERF_EN.
- When defined, adds:
  - Outputs PERF_GRANT0, PERF_GRANT1 (32 each): count accepted requests per requester.
  - Output PERF_CONFLICT (32): counts cycles where both requesters are eligible.
  - All three reset to 0, wrap modulo 2^32, and are unaffected by backpressure-stalled cycles except as defined.
- When undefined, these ports and counters do not exist. Functional behaviour is identical either way.

Test Plan:
- Reset, then req0 only: A=0x3F800000 (1.0), B=0x40000000 (2.0), op FLT → REQ_READY=01, next cycle RSP_VALID[0]=1, RSP0_R=1, tag echoed.
- Both valid every cycle, RSP_READY=11, 6 cycles → grants alternate 0,1,0,1,0,1 starting from requester 0; PRI ends at 0.
- Req0 FEQ 1.0 vs 1.0 with RSP_READY[0]=0 for 3 cycles, then a second req0 → second request not granted while slot full. RSP0_R=1 held 3 cycles. Second granted in the cycle RSP_READY[0] rises, with no bubble.
- Req1 op 11, operands 1.0/1.0 → granted, RSP1_R=0 next cycle.
- Req0 FLE 2.0 vs 2.0 mid-stream, RST_N pulsed low before capture → RSP_VALID=00, PRI=0 immediately; no response after release.
- PERF build: 4 conflict cycles plus 2 solo req0 grants → PERF_GRANT0=4, PERF_GRANT1=2, PERF_CONFLICT=4.
